// File: rtl/boron_dec_ctrl.sv
// Iterative Boron block decryption controller: whitening with K[NR], then NR
// inverse rounds, one per cycle, with round keys fetched from an external store.
module boron_dec_ctrl #(
  parameter int NR   = 25,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_text,
  output logic [IDXW-1:0] rk_idx,
  input  logic [63:0]     rk_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_text,
  output logic            busy,
  output logic [1:0]      dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, and data is held while valid && !ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [IDXW-1:0] NR_IDX    = IDXW'(NR);
  localparam logic [IDXW-1:0] NR_M1_IDX = IDXW'(NR - 1);

  state_e          state_q, state_d;
  logic [63:0]     s_q, s_d;
  logic [IDXW-1:0] r_q, r_d;
  logic [63:0]     round_out;

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    case (n)
      4'h0: inv_sbox = 4'hA;  4'h1: inv_sbox = 4'h3;
      4'h2: inv_sbox = 4'h9;  4'h3: inv_sbox = 4'hE;
      4'h4: inv_sbox = 4'h1;  4'h5: inv_sbox = 4'hD;
      4'h6: inv_sbox = 4'hF;  4'h7: inv_sbox = 4'h4;
      4'h8: inv_sbox = 4'hC;  4'h9: inv_sbox = 4'h5;
      4'hA: inv_sbox = 4'h7;  4'hB: inv_sbox = 4'h2;
      4'hC: inv_sbox = 4'h6;  4'hD: inv_sbox = 4'h8;
      4'hE: inv_sbox = 4'h0;  default: inv_sbox = 4'hB;
    endcase
  endfunction

  // Undo the XOR chain first, then the per-word left rotations (1,4,7,9).
  function automatic logic [63:0] inv_perm(input logic [63:0] y);
    logic [15:0] a0, a1, a2, a3;
    a0 = y[15:0];
    a1 = y[31:16] ^ y[15:0];
    a2 = y[47:32] ^ y[31:16];
    a3 = y[63:48] ^ y[47:32];
    inv_perm = {{a3[8:0], a3[15:9]}, {a2[6:0], a2[15:7]},
                {a1[3:0], a1[15:4]}, {a0[0], a0[15:1]}};
  endfunction

  // Forward shuffle places words as {w1,w3,w0,w2}.
  function automatic logic [63:0] inv_shuffle(input logic [63:0] y);
    inv_shuffle = {y[47:32], y[15:0], y[63:48], y[31:16]};
  endfunction

  function automatic logic [63:0] dec_round(input logic [63:0] x);
    logic [63:0] t;
    t = inv_shuffle(inv_perm(x));
    for (int i = 0; i < 16; i++) begin
      dec_round[4*i +: 4] = inv_sbox(t[4*i +: 4]);
    end
  endfunction

  assign round_out   = dec_round(s_q);
  assign out_text    = s_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = NR_IDX;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_d     = in_text ^ rk_data;
          r_d     = NR_M1_IDX;
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy   = 1'b1;
        rk_idx = r_q;
        s_d    = round_out ^ rk_data;
        if (r_q == '0) begin
          state_d = DONE;
        end else begin
          r_d = r_q - IDXW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: doc/boron_dec_ctrl.md
BORON_DEC_CTRL -- requirements
Module: boron_dec_ctrl

Interface
REQ-001 Parameter NR, default 25: number of Boron decryption rounds.
REQ-002 Parameter IDXW, default 5: width of round-key index; 2^IDXW SHALL be greater than NR.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  ciphertext present on in_text.
REQ-006 in_ready  output  1  controller able to accept a block.
REQ-007 in_text  input  64  ciphertext block.
REQ-008 rk_idx  output  IDXW  index of the round key currently required.
REQ-009 rk_data  input  64  round key K[rk_idx], driven combinationally by an external key store in the same cycle.
REQ-010 out_valid  output  1  plaintext present on out_text.
REQ-011 out_ready  input  1  downstream accepts out_text.
REQ-012 out_text  output  64  plaintext block.
REQ-013 busy  output  1  high in LOAD-complete round processing (state ROUND).

Function
REQ-014 States: IDLE, ROUND, DONE; 64-bit state register S; round counter R of width IDXW.
REQ-015 IDLE: in_ready=1, out_valid=0, busy=0, rk_idx=NR.
REQ-016 IDLE with in_valid=1: S <= in_text XOR rk_data (whitening with K[NR]); R <= NR-1; next state ROUND.
REQ-017 ROUND: in_ready=0, busy=1, rk_idx=R; each cycle S <= Dec_Round(S) XOR rk_data, where Dec_Round is the existing 64-bit inverse round (inverse permutation, inverse block shuffle, inverse S-box layer), instantiated once.
REQ-018 ROUND with R>0: R <= R-1, stay in ROUND; with R=0: next state DONE.
REQ-019 Round keys SHALL be requested in order NR, NR-1, ..., 0, each exactly once per block.
REQ-020 DONE: out_valid=1, out_text=S, in_ready=0, busy=0, rk_idx=NR; S held stable while out_ready=0.
REQ-021 DONE with out_ready=1: next state IDLE; in_ready rises in the following cycle (no same-cycle in/out overlap).
REQ-022 Latency: acceptance in cycle T gives out_valid=1 from cycle T+NR+1, i.e. 26 cycles at default.
REQ-023 Throughput: at most one block per NR+2 cycles.
REQ-024 in_valid or in_text changes during ROUND/DONE SHALL be ignored; in_text sampled only in the accept cycle.
REQ-025 out_text SHALL equal S in every state; it is meaningful only when out_valid=1.
REQ-026 rk_data SHALL be treated as valid only in the cycle its index is presented; the controller does not register keys.

Reset
REQ-027 rst=1 at any clock edge, including mid-ROUND or in DONE with out_ready=0: state <= IDLE, S <= 0, R <= 0; the in-flight block is discarded without out_valid.
REQ-028 Values after reset: in_ready=1, out_valid=0, busy=0, out_text=0, rk_idx=NR.
REQ-029 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-030 Round-trip: encrypt P=64'h0123456789ABCDEF with a fixed 80-bit key in the Boron reference model; feed the ciphertext with the model key schedule on rk_data -> out_text == P at cycle T+26.
REQ-031 Key order: monitor rk_idx from accept to DONE -> exact sequence 25,24,...,0, one value per cycle, no repeats.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_text stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
REQ-033 Mid-operation reset: assert rst in round 12 -> next cycle out_valid=0, in_ready=1, out_text=0; a new block then decrypts correctly.
REQ-034 Back-to-back: in_valid held high with 3 different ciphertexts, out_ready=1 -> three correct plaintexts, accepts spaced exactly 27 cycles apart.
REQ-035 Ignored input: toggle in_valid and in_text randomly during ROUND -> result unchanged versus quiet-input run.
